// File: rtl/alu_pkg.sv
// Shared ALU types and sizing helpers for the serial sltu comparator.
package alu_pkg;

  localparam int unsigned AluWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned chunk_count(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit subtract-with-borrow: {bout, d} = a - b - bin.
module sub_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

endmodule

// File: rtl/sltu_serial_compare.sv
// Multi-cycle unsigned compare (a < b, a == b) one chunk per clock, LS chunk first.
// Optional SLTU_SIGNED_EN adds an is_signed input giving slt semantics.
module sltu_serial_compare
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = AluWidth,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SLTU_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned NCHUNK = chunk_count(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

  state_e                     state_q, state_d;
  logic [WIDTH-1:0]           a_q, a_d, b_q, b_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       borrow_q, borrow_d;
  logic                       nonzero_q, nonzero_d;
  logic                       done_q, done_d;
  logic                       lt_q, lt_d;
  logic                       eq_q, eq_d;
  logic                       sign_flip_q, sign_flip_d;
  logic [BITS_PER_CYCLE-1:0]  diff;
  logic                       bout;

  sub_chunk #(
    .W (BITS_PER_CYCLE)
  ) u_sub_chunk (
    .a    (a_q[BITS_PER_CYCLE-1:0]),
    .b    (b_q[BITS_PER_CYCLE-1:0]),
    .bin  (borrow_q),
    .d    (diff),
    .bout (bout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    nonzero_d   = nonzero_q;
    done_d      = 1'b0;
    lt_d        = lt_q;
    eq_d        = eq_q;
    sign_flip_d = sign_flip_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          borrow_d  = 1'b0;
          nonzero_d = 1'b0;
          cnt_d     = '0;
          state_d   = StRun;
`ifdef SLTU_SIGNED_EN
          // Differing msbs invert the unsigned ordering when signed.
          sign_flip_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
          sign_flip_d = 1'b0;
`endif
        end
      end
      StRun: begin
        borrow_d  = bout;
        nonzero_d = nonzero_q | (|diff);
        a_d       = a_q >> BITS_PER_CYCLE;
        b_d       = b_q >> BITS_PER_CYCLE;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        lt_d    = borrow_q ^ sign_flip_q;
        eq_d    = ~nonzero_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      nonzero_q   <= 1'b0;
      done_q      <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      sign_flip_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      nonzero_q   <= nonzero_d;
      done_q      <= done_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      sign_flip_q <= sign_flip_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule
